// File: rtl/load_cell_seq.sv
// Rider-detect sequencer: samples left/right load cells via the shared A2D, derives weight/balance flags,
// and owns the stability timer. Optional A2D watchdog is enabled by defining LDCELL_TIMEOUT_EN.
module load_cell_seq #(
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] HYSTERESIS       = 12'h040,
  parameter logic [25:0] TMR_FULL_CNT     = 26'd65_000_000,
  parameter logic [15:0] SMPL_INTVL       = 16'd50_000,
  parameter logic [2:0]  LFT_CHNL         = 3'd0,
  parameter logic [2:0]  RGHT_CHNL        = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        a2d_req,
  output logic [2:0]  a2d_chnl,
  input  logic        a2d_rdy,
  input  logic [11:0] a2d_data,
  input  logic        clr_tmr,
  output logic        tmr_full,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        smpl_vld,
  output logic        a2d_err
);

  typedef enum logic [2:0] {
    WAIT_INTVL = 3'd0,
    REQ_L      = 3'd1,
    WAIT_L     = 3'd2,
    REQ_R      = 3'd3,
    WAIT_R     = 3'd4,
    CALC       = 3'd5
  } state_t;

  localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  state_t       state_r;
  state_t       state_nxt_s;
  logic [15:0]  intvl_cnt_r;
  logic [25:0]  tmr_cnt_r;
  logic         tmr_full_r;
  logic [11:0]  lft_ld_r;
  logic [11:0]  rght_ld_r;
  logic         sum_gt_min_r;
  logic         sum_lt_min_r;
  logic         diff_gt_1_4_r;
  logic         diff_gt_15_16_r;
  logic         smpl_vld_r;
  logic         a2d_req_r;
  logic [2:0]   a2d_chnl_r;
  logic         intvl_done_s;
  logic         wdog_to_s;
  logic [12:0]  sum_s;
  logic [11:0]  diff_s;
  logic [16:0]  sum_x15_s;

  assign intvl_done_s = (intvl_cnt_r == (SMPL_INTVL - 16'd1));

`ifdef LDCELL_TIMEOUT_EN
  logic [9:0] wdog_r;
  logic       a2d_err_r;
  logic       waiting_s;

  assign waiting_s = (state_r == WAIT_L) || (state_r == WAIT_R);
  // Timeout fires on the 1023rd waiting cycle so the request re-issues 1024 cycles after the original.
  assign wdog_to_s = waiting_s && (wdog_r == 10'd1022) && !a2d_rdy;

  // Conversion watchdog and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_r    <= 10'd0;
      a2d_err_r <= 1'b0;
    end else begin
      if (waiting_s) begin
        wdog_r <= wdog_r + 10'd1;
      end else begin
        wdog_r <= 10'd0;
      end
      a2d_err_r <= a2d_err_r | wdog_to_s;
    end
  end

  assign a2d_err = a2d_err_r;
`else
  assign wdog_to_s = 1'b0;
  assign a2d_err   = 1'b0;
`endif

  // Sequencer next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_INTVL: begin
        if (intvl_done_s) state_nxt_s = REQ_L;
        else              state_nxt_s = WAIT_INTVL;
      end
      REQ_L:  state_nxt_s = WAIT_L;
      WAIT_L: begin
        if (a2d_rdy)        state_nxt_s = REQ_R;
        else if (wdog_to_s) state_nxt_s = REQ_L;
        else                state_nxt_s = WAIT_L;
      end
      REQ_R:  state_nxt_s = WAIT_R;
      WAIT_R: begin
        if (a2d_rdy)        state_nxt_s = CALC;
        else if (wdog_to_s) state_nxt_s = REQ_R;
        else                state_nxt_s = WAIT_R;
      end
      CALC:    state_nxt_s = WAIT_INTVL;
      default: state_nxt_s = WAIT_INTVL;
    endcase
  end

  // State register and sample-interval counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= WAIT_INTVL;
      intvl_cnt_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == WAIT_INTVL) && !intvl_done_s) begin
        intvl_cnt_r <= intvl_cnt_r + 16'd1;
      end else begin
        intvl_cnt_r <= 16'd0;
      end
    end
  end

  // Request and channel are registered from the next state so they line up with REQ_x / WAIT_x.
  always_ff @(posedge clk) begin
    if (rst) begin
      a2d_req_r  <= 1'b0;
      a2d_chnl_r <= LFT_CHNL;
    end else begin
      a2d_req_r <= (state_nxt_s == REQ_L) || (state_nxt_s == REQ_R);
      case (state_nxt_s)
        REQ_L, WAIT_L: a2d_chnl_r <= LFT_CHNL;
        REQ_R, WAIT_R: a2d_chnl_r <= RGHT_CHNL;
        default:       a2d_chnl_r <= a2d_chnl_r;
      endcase
    end
  end

  // Unsigned sum, absolute difference and the 15*sum term for the balance ratios
  always_comb begin
    sum_s     = {1'b0, lft_ld_r} + {1'b0, rght_ld_r};
    diff_s    = 12'd0;
    if (lft_ld_r >= rght_ld_r) begin
      diff_s = lft_ld_r - rght_ld_r;
    end else begin
      diff_s = rght_ld_r - lft_ld_r;
    end
    sum_x15_s = {sum_s, 4'b0000} - {4'b0000, sum_s};
  end

  // Reading capture and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lft_ld_r        <= 12'd0;
      rght_ld_r       <= 12'd0;
      sum_gt_min_r    <= 1'b0;
      sum_lt_min_r    <= 1'b1;
      diff_gt_1_4_r   <= 1'b0;
      diff_gt_15_16_r <= 1'b0;
      smpl_vld_r      <= 1'b0;
    end else begin
      if ((state_r == WAIT_L) && a2d_rdy) lft_ld_r <= a2d_data;
      else                                lft_ld_r <= lft_ld_r;
      if ((state_r == WAIT_R) && a2d_rdy) rght_ld_r <= a2d_data;
      else                                rght_ld_r <= rght_ld_r;
      if (state_r == CALC) begin
        sum_gt_min_r    <= (sum_s > SUM_HI);
        sum_lt_min_r    <= (sum_s < SUM_LO);
        diff_gt_1_4_r   <= ({diff_s, 2'b00} > {1'b0, sum_s});
        diff_gt_15_16_r <= ({1'b0, diff_s, 4'b0000} > sum_x15_s);
      end else begin
        sum_gt_min_r    <= sum_gt_min_r;
        sum_lt_min_r    <= sum_lt_min_r;
        diff_gt_1_4_r   <= diff_gt_1_4_r;
        diff_gt_15_16_r <= diff_gt_15_16_r;
      end
      smpl_vld_r <= (state_r == CALC);
    end
  end

  // Stability timer: saturating count, full flag trails the count by one cycle, clear has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_cnt_r  <= 26'd0;
      tmr_full_r <= 1'b0;
    end else if (clr_tmr) begin
      tmr_cnt_r  <= 26'd0;
      tmr_full_r <= 1'b0;
    end else begin
      if (tmr_cnt_r != TMR_FULL_CNT) tmr_cnt_r <= tmr_cnt_r + 26'd1;
      else                           tmr_cnt_r <= tmr_cnt_r;
      tmr_full_r <= (tmr_cnt_r == TMR_FULL_CNT);
    end
  end

  assign a2d_req       = a2d_req_r;
  assign a2d_chnl      = a2d_chnl_r;
  assign tmr_full      = tmr_full_r;
  assign lft_ld        = lft_ld_r;
  assign rght_ld       = rght_ld_r;
  assign sum_gt_min    = sum_gt_min_r;
  assign sum_lt_min    = sum_lt_min_r;
  assign diff_gt_1_4   = diff_gt_1_4_r;
  assign diff_gt_15_16 = diff_gt_15_16_r;
  assign smpl_vld      = smpl_vld_r;

endmodule

// File: tb/tb_load_cell_seq.sv
// Self-checking bench for load_cell_seq: directed plus randomized sample rounds against an arithmetic model.
module tb_load_cell_seq;

  localparam logic [15:0] INTVL   = 16'd8;
  localparam logic [25:0] TFULL   = 26'd20;
  localparam int          L_CH    = 0;
  localparam int          R_CH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a2d_req;
  logic [2:0]  a2d_chnl;
  logic        a2d_rdy;
  logic [11:0] a2d_data;
  logic        clr_tmr;
  logic        tmr_full;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        smpl_vld;
  logic        a2d_err;

  int checks = 0;
  int errors = 0;
  int exp_l  = 0;
  int exp_r  = 0;

  load_cell_seq #(
    .TMR_FULL_CNT(TFULL),
    .SMPL_INTVL  (INTVL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .a2d_req      (a2d_req),
    .a2d_chnl     (a2d_chnl),
    .a2d_rdy      (a2d_rdy),
    .a2d_data     (a2d_data),
    .clr_tmr      (clr_tmr),
    .tmr_full     (tmr_full),
    .lft_ld       (lft_ld),
    .rght_ld      (rght_ld),
    .sum_gt_min   (sum_gt_min),
    .sum_lt_min   (sum_lt_min),
    .diff_gt_1_4  (diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16),
    .smpl_vld     (smpl_vld),
    .a2d_err      (a2d_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags from plain integer arithmetic: {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16}
  function automatic logic [3:0] ref_flags(input int l, input int r);
    int s;
    int d;
    s = l + r;
    d = (l > r) ? (l - r) : (r - l);
    return {s > (512 + 64), s < (512 - 64), (4 * d) > s, (16 * d) > (15 * s)};
  endfunction

  function automatic logic [31:0] dut_flags();
    return 32'({sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16});
  endfunction

  task automatic step();
    @(negedge clk);
    a2d_data = 12'($urandom);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_lft"},   32'(lft_ld),  32'(exp_l));
    chk({tag, "_rght"},  32'(rght_ld), 32'(exp_r));
    chk({tag, "_flags"}, dut_flags(),  32'(ref_flags(exp_l, exp_r)));
  endtask

  // Waits for a2d_req, starting with the current cycle; reports cycles elapsed.
  task automatic wait_req(input string tag, output int cycles);
    bit ok;
    bit vld_seen;
    ok = 1'b0;
    vld_seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (a2d_req) begin
        ok = 1'b1;
        break;
      end
      vld_seen |= smpl_vld;
      step();
      cycles++;
    end
    chk({tag, "_req_seen"}, 32'(ok), 32'd1);
    chk({tag, "_no_vld_idle"}, 32'(vld_seen), 32'd0);
  endtask

  // Called in a cycle with a2d_req high; answers after lat cycles, returns one cycle after rdy.
  task automatic serve(input string tag, input int ch, input logic [11:0] data, input int lat);
    bit hold_ok;
    chk({tag, "_chnl"}, 32'(a2d_chnl), 32'(ch));
    hold_ok = 1'b1;
    for (int i = 0; i < lat; i++) begin
      step();
      if (a2d_req !== 1'b0 || a2d_chnl !== 3'(ch)) hold_ok = 1'b0;
    end
    chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
    a2d_rdy  = 1'b1;
    a2d_data = data;
    @(negedge clk);
    a2d_rdy  = 1'b0;
    a2d_data = 12'($urandom);
  endtask

  task automatic do_round(input string tag, input logic [11:0] l, input logic [11:0] r,
                          input int latl, input int latr);
    int c;
    wait_req(tag, c);
    serve({tag, "_L"}, L_CH, l, latl);
    chk({tag, "_lcap"}, 32'(lft_ld), 32'(l));
    wait_req({tag, "_R"}, c);
    chk({tag, "_r_req_next"}, 32'(c), 32'd0);
    serve({tag, "_R"}, R_CH, r, latr);
    chk({tag, "_rcap"}, 32'(rght_ld), 32'(r));
    chk({tag, "_vld_early"}, 32'(smpl_vld), 32'd0);
    step();
    exp_l = int'(l);
    exp_r = int'(r);
    chk({tag, "_vld"}, 32'(smpl_vld), 32'd1);
    chk({tag, "_flags"}, dut_flags(), 32'(ref_flags(exp_l, exp_r)));
    step();
    chk({tag, "_vld_pulse"}, 32'(smpl_vld), 32'd0);
    chk({tag, "_err"}, 32'(a2d_err), 32'd0);
  endtask

  task automatic spurious_rdy(input string tag);
    a2d_rdy  = 1'b1;
    a2d_data = 12'($urandom);
    step();
    a2d_rdy = 1'b0;
    chk({tag, "_no_vld"}, 32'(smpl_vld), 32'd0);
    step();
    chk({tag, "_no_vld2"}, 32'(smpl_vld), 32'd0);
    check_state(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},  32'(a2d_req),  32'd0);
    chk({tag, "_chnl"}, 32'(a2d_chnl), 32'(L_CH));
    chk({tag, "_vld"},  32'(smpl_vld), 32'd0);
    chk({tag, "_tmr"},  32'(tmr_full), 32'd0);
    chk({tag, "_err"},  32'(a2d_err),  32'd0);
    chk({tag, "_flagsrst"}, dut_flags(), 32'h4);
    check_state(tag);
  endtask

  initial begin
    int c;
    rst      = 1'b1;
    a2d_rdy  = 1'b0;
    a2d_data = 12'd0;
    clr_tmr  = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");

    // First request comes after exactly SMPL_INTVL idle cycles
    rst = 1'b0;
    wait_req("intvl", c);
    chk("intvl_len", 32'(c), 32'(INTVL));

    // Timer: full exactly TFULL+1 cycles after clear deasserts, saturates, clears next cycle
    clr_tmr = 1'b1;
    step();
    chk("tmr_clr", 32'(tmr_full), 32'd0);
    clr_tmr = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      step();
      chk("tmr_full", 32'(tmr_full), 32'(n >= int'(TFULL) + 1));
    end
    clr_tmr = 1'b1;
    step();
    chk("tmr_reclr", 32'(tmr_full), 32'd0);
    clr_tmr = 1'b0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_l = 0;
    exp_r = 0;
    check_reset_vals("reset2");

    do_round("r180", 12'h180, 12'h180, 3, 3);
    spurious_rdy("spur1");
    do_round("lobnd", 12'h0E0, 12'h0E0, 2, 4);
    do_round("below", 12'h0DF, 12'h0DF, 1, 1);
    do_round("d14",   12'h300, 12'h100, 3, 2);
    do_round("d1516", 12'h3F0, 12'h008, 2, 3);
    do_round("zero",  12'h000, 12'h000, 1, 2);
    do_round("maxs",  12'hFFF, 12'hFFF, 2, 1);
    do_round("maxd",  12'h000, 12'hFFF, 4, 1);
    do_round("hibnd", 12'h120, 12'h120, 1, 1);

    for (int k = 0; k < 14; k++) begin
      do_round("rand", 12'($urandom), 12'($urandom), int'($urandom_range(6, 1)), int'($urandom_range(6, 1)));
      if ($urandom_range(1, 0) == 1) spurious_rdy("rspur");
    end

    // Reset while waiting for the right conversion, with a coincident rdy that must be dropped
    wait_req("rstmid", c);
    serve("rstmid_L", L_CH, 12'h5A5, 2);
    step();
    step();
    rst      = 1'b1;
    a2d_rdy  = 1'b1;
    a2d_data = 12'h777;
    step();
    rst     = 1'b0;
    a2d_rdy = 1'b0;
    exp_l = 0;
    exp_r = 0;
    check_reset_vals("rstmid");
    step();
    check_state("rstmid_after");
    do_round("recover", 12'h250, 12'h010, 2, 2);

`ifdef LDCELL_TIMEOUT_EN
    wait_req("to", c);
    chk("to_err_before", 32'(a2d_err), 32'd0);
    c = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      c++;
      if (a2d_req) break;
    end
    chk("to_gap", 32'(c), 32'd1024);
    chk("to_chnl", 32'(a2d_chnl), 32'(L_CH));
    chk("to_err", 32'(a2d_err), 32'd1);
    repeat (5) step();
    chk("to_err_sticky", 32'(a2d_err), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
